// File: rtl/odd_even_pkg.sv
// Shared types and constants for the odd/even counter stream checker.
package odd_even_pkg;

  // SYNC and RESYNC behave identically; they are kept apart only so a
  // debugger can tell "fresh out of reset" from "recovering after an event".
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RESYNC = 2'd1,
    LOCK   = 2'd2
  } state_t;

  typedef enum logic {
    MODE_EVEN = 1'b0,
    MODE_ODD  = 1'b1
  } mode_t;

  // Distance between consecutive values of the producer's sequence.
  localparam int STEP = 2;

endpackage

// File: rtl/odd_even_cnt_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; it sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Clear has priority; increments stop once every bit is set.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/odd_even_cnt_checker.sv
// Receive-side monitor for the odd/even counter stream. Tracks the next
// expected value, flags sequence and parity violations with one-cycle
// pulses and keeps a saturating error count. All outputs are registered.
module odd_even_cnt_checker
  import odd_even_pkg::*;
#(
  parameter int W     = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode_in,
  input  logic [W-1:0]     cnt_in,
  output logic             locked,
  output logic [W-1:0]     exp_cnt,
  output logic             seq_err,
  output logic             par_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  state_t         state_q, state_d;
  mode_t          mode_q, mode_d;
  logic [W-1:0]   exp_d;
  logic           locked_d, seq_d, par_d, wrap_d;
  logic           err_inc;
  logic           mode_chg, par_ok, top_val;

  // A mode change outranks every check: the producer may lag by a cycle.
  assign mode_chg = in_valid && (mode_t'(mode_in) != mode_q);
  assign par_ok   = (cnt_in[0] == mode_in);
  // An accepted value in LOCK already has the right parity, so the upper
  // bits being all ones identifies 2^W-2 (even) or 2^W-1 (odd).
  assign top_val  = &cnt_in[W-1:1];

  // Next-state and next-output decode; everything holds when in_valid=0.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    exp_d    = exp_cnt;
    locked_d = locked;
    seq_d    = 1'b0;
    par_d    = 1'b0;
    wrap_d   = 1'b0;
    err_inc  = 1'b0;
    if (in_valid) begin
      if (mode_chg) begin
        state_d  = RESYNC;
        mode_d   = mode_t'(mode_in);
        locked_d = 1'b0;
      end else if (state_q == LOCK) begin
        if (cnt_in == exp_cnt) begin
          exp_d  = exp_cnt + W'(STEP);
          wrap_d = top_val;
        end else begin
          // The bad value is never adopted; recapture from the next sample.
          seq_d    = 1'b1;
          err_inc  = 1'b1;
          state_d  = RESYNC;
          locked_d = 1'b0;
        end
      end else if (par_ok) begin
        exp_d    = cnt_in + W'(STEP);
        state_d  = LOCK;
        locked_d = 1'b1;
      end else begin
        par_d   = 1'b1;
        err_inc = 1'b1;
      end
    end
  end

  // State and output registers; reset clears all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      mode_q  <= MODE_EVEN;
      exp_cnt <= '0;
      locked  <= 1'b0;
      seq_err <= 1'b0;
      par_err <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      exp_cnt <= exp_d;
      locked  <= locked_d;
      seq_err <= seq_d;
      par_err <= par_d;
      wrap    <= wrap_d;
    end
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk (clk),
    .clr (rst),
    .inc (err_inc),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_odd_even_cnt_checker.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_odd_even_cnt_checker;

  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         mode_in = 1'b0;
  logic [W-1:0] cnt_in = '0;

  logic         locked, seq_err, par_err, wrap;
  logic [W-1:0] exp_cnt;
  logic [7:0]   err_cnt;
  logic         locked2, seq_err2, par_err2, wrap2;
  logic [W-1:0] exp_cnt2;
  logic [1:0]   err_cnt2;

  odd_even_cnt_checker #(.W(W), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode_in(mode_in),
    .cnt_in(cnt_in), .locked(locked), .exp_cnt(exp_cnt),
    .seq_err(seq_err), .par_err(par_err), .wrap(wrap), .err_cnt(err_cnt)
  );

  odd_even_cnt_checker #(.W(W), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode_in(mode_in),
    .cnt_in(cnt_in), .locked(locked2), .exp_cnt(exp_cnt2),
    .seq_err(seq_err2), .par_err(par_err2), .wrap(wrap2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int n_cmp   = 0;
  int miss    = 0;

  // Behavioural model: what the outputs must show after the next edge.
  bit m_locked = 0;
  int m_exp    = 0;
  bit m_mode   = 0;
  int m_err    = 0;
  int m_err2   = 0;
  bit m_seq = 0, m_par = 0, m_wrap = 0;

  function automatic int sat(input int v, input int lim);
    return (v >= lim) ? lim : v;
  endfunction

  task automatic model_step(input bit r, input bit v, input bit m, input int c);
    m_seq = 0; m_par = 0; m_wrap = 0;
    if (r) begin
      m_locked = 0; m_exp = 0; m_mode = 0; m_err = 0; m_err2 = 0;
    end else if (v) begin
      if (m != m_mode) begin
        m_mode   = m;
        m_locked = 0;
      end else if (!m_locked) begin
        if ((c % 2) == m) begin
          m_exp    = (c + 2) % MODV;
          m_locked = 1;
        end else begin
          m_par  = 1;
          m_err  = sat(m_err + 1, 255);
          m_err2 = sat(m_err2 + 1, 3);
        end
      end else if (c == m_exp) begin
        m_exp  = (m_exp + 2) % MODV;
        m_wrap = (c >= MODV - 2);
      end else begin
        m_seq    = 1;
        m_locked = 0;
        m_err    = sat(m_err + 1, 255);
        m_err2   = sat(m_err2 + 1, 3);
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, vectors, act, req);
    end
  endtask

  task automatic compare_all();
    cmp("locked", int'(locked), int'(m_locked));
    cmp("seq_err", int'(seq_err), int'(m_seq));
    cmp("par_err", int'(par_err), int'(m_par));
    cmp("wrap", int'(wrap), int'(m_wrap));
    cmp("err_cnt", int'(err_cnt), m_err);
    if (m_locked) cmp("exp_cnt", int'(exp_cnt), m_exp);
    cmp("locked2", int'(locked2), int'(m_locked));
    cmp("seq_err2", int'(seq_err2), int'(m_seq));
    cmp("par_err2", int'(par_err2), int'(m_par));
    cmp("wrap2", int'(wrap2), int'(m_wrap));
    cmp("err_cnt2", int'(err_cnt2), m_err2);
    if (m_locked) cmp("exp_cnt2", int'(exp_cnt2), m_exp);
  endtask

  // Apply one sample, advance the model, then check after the edge.
  task automatic cyc(input bit r, input bit v, input bit m, input int c);
    rst = r; in_valid = v; mode_in = m; cnt_in = W'(c);
    model_step(r, v, m, c);
    @(negedge clk);
    vectors++;
    compare_all();
  endtask

  initial begin
    int c, r;
    bit m, v, rr;

    // 1: reset, then the full even sequence with one wrap.
    cyc(1, 0, 0, 0);
    cmp("t1_rst_locked", int'(locked), 0);
    cmp("t1_rst_exp", int'(exp_cnt), 0);
    cmp("t1_rst_err", int'(err_cnt), 0);
    for (int i = 0; i <= 14; i += 2) begin
      cyc(0, 1, 0, i);
      if (i == 0) begin
        cmp("t1_lock", int'(locked), 1);
        cmp("t1_exp2", int'(exp_cnt), 2);
      end
      if (i == 14) cmp("t1_wrap", int'(wrap), 1);
    end
    cyc(0, 1, 0, 0);
    cmp("t1_wrap_once", int'(wrap), 0);
    cyc(0, 1, 0, 2);
    cmp("t1_exp4", int'(exp_cnt), 4);
    cmp("t1_noerr", int'(err_cnt), 0);

    // 2: sequence break on 7, relock on 8.
    cyc(0, 1, 0, 4);
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 7);
    cmp("t2_seq", int'(seq_err), 1);
    cmp("t2_err1", int'(err_cnt), 1);
    cmp("t2_unlock", int'(locked), 0);
    cyc(0, 1, 0, 8);
    cmp("t2_relock", int'(locked), 1);
    cmp("t2_exp10", int'(exp_cnt), 10);

    // 3: mode flips to odd while 6 is still observed.
    cyc(0, 1, 1, 6);
    cmp("t3_nopar", int'(par_err), 0);
    cmp("t3_noseq", int'(seq_err), 0);
    cyc(0, 1, 1, 7);
    cmp("t3_lock", int'(locked), 1);
    cyc(0, 1, 1, 9);
    cyc(0, 1, 1, 11);
    cmp("t3_exp13", int'(exp_cnt), 13);
    cmp("t3_err1", int'(err_cnt), 1);

    // 4: odd mode after reset; the first odd sample is itself a mode change.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 5);
    cmp("t4_mchg_nolock", int'(locked), 0);
    cyc(0, 1, 1, 4);
    cmp("t4_par", int'(par_err), 1);
    cmp("t4_err1", int'(err_cnt), 1);
    cmp("t4_nolock", int'(locked), 0);
    cyc(0, 1, 1, 5);
    cmp("t4_lock", int'(locked), 1);
    cmp("t4_exp7", int'(exp_cnt), 7);

    // 5: gap in valid with garbage on the data.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 6);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, $urandom_range(0, MODV - 1));
      cmp("t5_hold_exp", int'(exp_cnt), 8);
    end
    cyc(0, 1, 0, 8);
    cmp("t5_lock", int'(locked), 1);
    cmp("t5_exp10", int'(exp_cnt), 10);

    // 6: saturation of the narrow counter, then reset mid-stream.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 2 * i + 1);
    cmp("t6_sat3", int'(err_cnt2), 3);
    cmp("t6_err5", int'(err_cnt), 5);
    cyc(0, 1, 0, 2);
    cyc(1, 1, 0, 4);
    cmp("t6_rst_locked", int'(locked), 0);
    cmp("t6_rst_exp", int'(exp_cnt), 0);
    cmp("t6_rst_err", int'(err_cnt), 0);
    cmp("t6_rst_err2", int'(err_cnt2), 0);

    // Randomized traffic, mostly well-formed with sprinkled faults.
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 199));
      rr = (r == 0);
      v  = ($urandom_range(0, 9) != 0);
      m  = m_mode;
      if ($urandom_range(0, 39) == 0) m = ~m;
      if (m_locked && $urandom_range(0, 9) != 0) c = m_exp;
      else if (!m_locked && $urandom_range(0, 9) < 7)
        c = (2 * int'($urandom_range(0, MODV / 2 - 1)) + int'(m)) % MODV;
      else c = int'($urandom_range(0, MODV - 1));
      cyc(rr, v, m, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
